// File: rtl/sprite_update_sched.sv
// Sprite position update queue: buffers CPU (id, x, y) writes and replays them to graphics RAM only in vblank.
// Optional build macro SPRITE_COALESCE_EN merges a new update into a queued entry with the same id.
module sprite_update_sched #(
   parameter int DEPTH       = 4,
   parameter int NUM_SPRITES = 3,
   parameter int WRN_HOLD    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [7:0]               req_id,
   input  logic [9:0]               req_x,
   input  logic [8:0]               req_y,
   input  logic                     vblank,
   output logic [7:0]               gr_id,
   output logic [9:0]               gr_x,
   output logic [8:0]               gr_y,
   output logic                     gr_wrn,
   output logic [$clog2(DEPTH):0]   pending,
   output logic [7:0]               drop_cnt,
   output logic [1:0]               dbg_state
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int HW = (WRN_HOLD > 1) ? $clog2(WRN_HOLD) : 1;
   localparam logic [7:0] NUM_ID = 8'(NUM_SPRITES);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER} state_t;

   state_t          state, state_nxt;
   logic [HW-1:0]   hold_cnt, hold_nxt;
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_nxt;
   logic            accept, id_ok, push, upd, pop, hit;
   logic [PW-1:0]   hit_idx;

   logic [7:0]      mem_id [DEPTH];
   logic [9:0]      mem_x  [DEPTH];
   logic [8:0]      mem_y  [DEPTH];

   // Handshake: a request transfers on a clk edge where req_valid && req_ready; req_ready is a
   // flop (= !full) so the requester never sees a combinational path from the write-side FSM.
   assign accept = req_valid && req_ready;
   assign id_ok  = req_id < NUM_ID;
   assign push   = accept && id_ok && !hit;
   assign upd    = accept && id_ok && hit;

`ifdef SPRITE_COALESCE_EN
   logic [PW-1:0] offs [DEPTH];

   // The head being popped this cycle is already on its way out and must not absorb the update.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs[i] = PW'(i) - rd_ptr;
         if (({1'b0, offs[i]} < count) && !(pop && (PW'(i) == rd_ptr)) &&
             (mem_id[i] == req_id)) begin
            hit     = 1'b1;
            hit_idx = PW'(i);
         end
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_idx = '0;
`endif

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      pop       = 1'b0;
      case (state)
         S_IDLE: begin
            if (vblank && (count != '0)) begin
               pop       = 1'b1;
               state_nxt = S_SETUP;
            end
         end
         S_SETUP: begin
            state_nxt = S_STROBE;
            hold_nxt  = '0;
         end
         S_STROBE: begin
            if (hold_cnt == HW'(WRN_HOLD - 1)) state_nxt = S_RECOVER;
            else                               hold_nxt  = hold_cnt + 1'b1;
         end
         S_RECOVER: state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + 1'b1;
      else if (pop && !push) count_nxt = count - 1'b1;
   end

   // Registered strobe so the RAM never sees decode glitches; reset clears it without an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         hold_cnt <= '0;
         gr_wrn   <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         gr_wrn   <= (state_nxt == S_STROBE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         req_ready <= 1'b1;
         drop_cnt  <= '0;
         gr_id     <= '0;
         gr_x      <= '0;
         gr_y      <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            gr_id  <= mem_id[rd_ptr];
            gr_x   <= mem_x[rd_ptr];
            gr_y   <= mem_y[rd_ptr];
         end
         count     <= count_nxt;
         req_ready <= (count_nxt != CW'(DEPTH));
         if (accept && !id_ok && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_id[wr_ptr] <= req_id;
         mem_x[wr_ptr]  <= req_x;
         mem_y[wr_ptr]  <= req_y;
      end
      if (upd) begin
         mem_x[hit_idx] <= req_x;
         mem_y[hit_idx] <= req_y;
      end
   end

   assign pending   = count;
   assign dbg_state = state;

endmodule

// File: tb/tb_sprite_update_sched.sv
// Bench for sprite_update_sched: vector table plus hand-written vblank/reset sequences, with a
// write scoreboard fed by accepted requests and drained at each gr_wrn rising edge.
module tb_sprite_update_sched;

   localparam int DEPTH       = 4;
   localparam int NUM_SPRITES = 3;
   localparam int WRN_HOLD    = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic [7:0] req_id = '0;
   logic [9:0] req_x = '0;
   logic [8:0] req_y = '0;
   logic       vblank = 1'b0;
   logic       req_ready, gr_wrn;
   logic [7:0] gr_id, drop_cnt;
   logic [9:0] gr_x;
   logic [8:0] gr_y;
   logic [2:0] pending;
   logic [1:0] dbg_state;

   sprite_update_sched #(.DEPTH(DEPTH), .NUM_SPRITES(NUM_SPRITES), .WRN_HOLD(WRN_HOLD)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_id(req_id), .req_x(req_x), .req_y(req_y), .vblank(vblank),
      .gr_id(gr_id), .gr_x(gr_x), .gr_y(gr_y), .gr_wrn(gr_wrn),
      .pending(pending), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_cmp = 0;
   int n_err = 0;
   int n_rise = 0;
   int exp_drop = 0;
   logic [26:0] exp_q[$];
   int rise_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s", name);
   endtask

   // scoreboard: every rising gr_wrn must carry the oldest expected write
   logic        prev_wrn = 1'b0;
   int          width = 0;
   logic [26:0] prev_data = '0;
   logic [26:0] strobe_data = '0;
   logic [26:0] cur;
   always @(negedge clk) begin
      cur = {gr_id, gr_x, gr_y};
      if (rst) begin
         prev_wrn = 1'b0;
         width    = 0;
      end else begin
         if (gr_wrn && !prev_wrn) begin
            n_rise++;
            rise_cyc.push_back(cyc);
            check("setup_stable", 32'(prev_data), 32'(cur));
            if (exp_q.size() == 0) fail("unexpected_write");
            else check("write_data", 32'(cur), 32'(exp_q.pop_front()));
            strobe_data = cur;
            width = 1;
         end else if (gr_wrn) begin
            width++;
            check("strobe_hold", 32'(cur), 32'(strobe_data));
         end else if (prev_wrn) begin
            check("strobe_width", width, WRN_HOLD);
         end
         prev_wrn = gr_wrn;
      end
      prev_data = cur;
   end

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_accept(input logic [7:0] id, input logic [9:0] x, input logic [8:0] y);
`ifdef SPRITE_COALESCE_EN
      bit hit;
      hit = 1'b0;
`endif
      if (id >= NUM_SPRITES) begin
         if (exp_drop < 255) exp_drop++;
      end else begin
`ifdef SPRITE_COALESCE_EN
         foreach (exp_q[i]) if (exp_q[i][26:19] == id) begin
            exp_q[i] = {id, x, y};
            hit = 1'b1;
         end
         if (!hit) exp_q.push_back({id, x, y});
`else
         exp_q.push_back({id, x, y});
`endif
      end
   endtask

   task automatic push(input logic [7:0] id, input logic [9:0] x, input logic [8:0] y);
      int   n;
      logic acc;
      n = 0;
      req_valid = 1'b1; req_id = id; req_x = x; req_y = y;
      do begin
         acc = req_ready;
         step(1);
         n++;
      end while (!acc && n < 40);
      req_valid = 1'b0;
      if (!acc) fail("push_timeout");
      else model_accept(id, x, y);
   endtask

   task automatic drain();
      int n;
      n = 0;
      vblank = 1'b1;
      while (exp_q.size() != 0 && n < 200) begin
         step(1);
         n++;
      end
      if (exp_q.size() != 0) fail("drain_timeout");
      step(WRN_HOLD + 2);
      vblank = 1'b0;
      step(1);
   endtask

   task automatic wait_strobe();
      int n;
      n = 0;
      while (!gr_wrn && n < 20) begin
         step(1);
         n++;
      end
      if (!gr_wrn) fail("strobe_timeout");
   endtask

   typedef struct {
      logic [7:0] id;
      logic [9:0] x;
      logic [8:0] y;
      logic [2:0] exp_pend;
      logic [7:0] exp_drop;
   } vec_t;
   vec_t tbl[6];

   initial begin
      int r0, i0, n;
      logic acc;
      tbl[0] = '{8'd7,   10'h000, 9'h000, 3'd0, 8'd1};
      tbl[1] = '{8'd0,   10'h001, 9'h002, 3'd1, 8'd1};
      tbl[2] = '{8'd3,   10'h2AA, 9'h155, 3'd1, 8'd2};
      tbl[3] = '{8'd2,   10'h3FF, 9'h1FF, 3'd2, 8'd2};
      tbl[4] = '{8'd255, 10'h123, 9'h045, 3'd2, 8'd3};
      tbl[5] = '{8'd1,   10'h155, 9'h0AA, 3'd3, 8'd3};

      // reset state
      step(3);
      rst = 1'b0;
      step(1);
      check("rst_ready", 32'(req_ready), 1);
      check("rst_wrn", 32'(gr_wrn), 0);
      check("rst_pending", 32'(pending), 0);
      check("rst_drop", 32'(drop_cnt), 0);
      check("rst_gr_data", 32'({gr_id, gr_x, gr_y}), 0);
      check("rst_state", 32'(dbg_state), 0);

      // single write timing
      push(8'd1, 10'h100, 9'h0F0);
      check("t2_pending", 32'(pending), 1);
      r0 = n_rise;
      step(3);
      check("t2_no_strobe", n_rise, r0);
      vblank = 1'b1;
      step(1);
      check("t2_data", 32'({gr_id, gr_x, gr_y}), 32'({8'd1, 10'h100, 9'h0F0}));
      check("t2_setup_wrn", 32'(gr_wrn), 0);
      check("t2_pending0", 32'(pending), 0);
      step(1);
      check("t2_wrn_hi1", 32'(gr_wrn), 1);
      step(1);
      check("t2_wrn_hi2", 32'(gr_wrn), 1);
      step(1);
      check("t2_wrn_lo", 32'(gr_wrn), 0);
      vblank = 1'b0;
      step(2);
      check("t2_data_held", 32'({gr_id, gr_x, gr_y}), 32'({8'd1, 10'h100, 9'h0F0}));

      // table-driven accept/drop vectors
      foreach (tbl[k]) begin
         push(tbl[k].id, tbl[k].x, tbl[k].y);
         check($sformatf("vec%0d_pending", k), 32'(pending), 32'(tbl[k].exp_pend));
         check($sformatf("vec%0d_drop", k), 32'(drop_cnt), 32'(tbl[k].exp_drop));
      end
      drain();
      check("vec_pending0", 32'(pending), 0);

      for (int i = 0; i < 300; i++)
         push(8'($urandom_range(NUM_SPRITES, 255)), 10'($urandom_range(0, 1023)), 9'($urandom_range(0, 511)));
      check("drop_sat", 32'(drop_cnt), 32'h0FF);
      check("drop_pending", 32'(pending), 0);

`ifndef SPRITE_COALESCE_EN
      // full queue, held fifth request, back-to-back writes
      push(8'd0, 10'h011, 9'h021);
      push(8'd1, 10'h012, 9'h022);
      push(8'd2, 10'h013, 9'h023);
      push(8'd0, 10'h014, 9'h024);
      check("full_ready", 32'(req_ready), 0);
      check("full_pending", 32'(pending), 4);
      i0 = rise_cyc.size();
      req_valid = 1'b1; req_id = 8'd1; req_x = 10'h015; req_y = 9'h025;
      vblank = 1'b1;
      n = 0;
      do begin
         acc = req_ready;
         step(1);
         n++;
      end while (!acc && n < 20);
      req_valid = 1'b0;
      check("full_accept_cycle", n, 2);
      if (acc) model_accept(8'd1, 10'h015, 9'h025);
      drain();
      if (rise_cyc.size() < i0 + 5) fail("full_write_count");
      else for (int k = 1; k < 5; k++)
         check($sformatf("full_spacing%0d", k), rise_cyc[i0 + k] - rise_cyc[i0 + k - 1], WRN_HOLD + 3);
`else
      push(8'd0, 10'h011, 9'h021);
      push(8'd1, 10'h012, 9'h022);
      push(8'd2, 10'h013, 9'h023);
      push(8'd0, 10'h014, 9'h024);
      check("merge_pending3", 32'(pending), 3);
      check("merge_ready", 32'(req_ready), 1);
      drain();
`endif

      // vblank falls mid-strobe
      push(8'd1, 10'h0A1, 9'h0B1);
      push(8'd2, 10'h0A2, 9'h0B2);
      r0 = n_rise;
      vblank = 1'b1;
      wait_strobe();
      vblank = 1'b0;
      step(12);
      check("vb_pending", 32'(pending), 1);
      check("vb_one_write", n_rise - r0, 1);
      drain();

      // same-id updates
      push(8'd2, 10'd5, 9'd5);
      push(8'd2, 10'd9, 9'd9);
      r0 = n_rise;
`ifdef SPRITE_COALESCE_EN
      check("same_id_pending", 32'(pending), 1);
      drain();
      check("same_id_writes", n_rise - r0, 1);
`else
      check("same_id_pending", 32'(pending), 2);
      drain();
      check("same_id_writes", n_rise - r0, 2);
`endif

      // reset during strobe
      push(8'd0, 10'h0C0, 9'h0D0);
      push(8'd1, 10'h0C1, 9'h0D1);
      vblank = 1'b1;
      wait_strobe();
      #2 rst = 1'b1;
      #1;
      check("rst_mid_wrn", 32'(gr_wrn), 0);
      check("rst_mid_pending", 32'(pending), 0);
      exp_q.delete();
      exp_drop = 0;
      r0 = n_rise;
      vblank = 1'b0;
      step(2);
      rst = 1'b0;
      vblank = 1'b1;
      step(8);
      vblank = 1'b0;
      check("rst_mid_no_edge", n_rise - r0, 0);
      check("rst_mid_pending_after", 32'(pending), 0);
      check("rst_mid_ready", 32'(req_ready), 1);

      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout");
      $fatal(1, "time limit");
   end

endmodule
